// File: rtl/byte_unstriping_rx.sv
// Four-lane byte unstriper: per-lane skew FIFOs drained in strict round-robin
// lane order into a single registered byte stream.
module byte_unstriping_rx #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_ptr,
    output logic       overflow
);

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ZERO_CNT = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

    logic [7:0]       din_s    [4];
    logic [3:0]       vin_s;
    logic [7:0]       mem_r    [4][DEPTH];
    logic [PTR_W-1:0] wr_ptr_r [4];
    logic [PTR_W-1:0] rd_ptr_r [4];
    logic [PTR_W:0]   count_r  [4];
    logic [3:0]       push_s;
    logic [3:0]       pop_s;
    logic             drop_s;
    lane_state_t      state_r;
    lane_state_t      state_nxt_s;
    logic [7:0]       data_nxt_s;
    logic             valid_nxt_s;
    logic [7:0]       data_out_r;
    logic             valid_out_r;
    logic             overflow_r;

    assign din_s[0] = data_in0;
    assign din_s[1] = data_in1;
    assign din_s[2] = data_in2;
    assign din_s[3] = data_in3;
    assign vin_s    = {valid_in3, valid_in2, valid_in1, valid_in0};

    // Push/pop qualification; a full lane still accepts a byte when it pops on the same edge
    always_comb begin
        push_s = 4'b0000;
        pop_s  = 4'b0000;
        drop_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pop_s[i]  = (2'(i) == state_r) && (count_r[i] != ZERO_CNT);
            push_s[i] = vin_s[i] && ((count_r[i] != FULL_CNT) || pop_s[i]);
            drop_s    = drop_s | (vin_s[i] & ~push_s[i]);
        end
    end

    // Next lane and output byte; an empty current lane stalls the whole stream
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_out_r;
        valid_nxt_s = 1'b0;
        if (pop_s[state_r]) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = mem_r[state_r][rd_ptr_r[state_r]];
            case (state_r)
                LANE0:   state_nxt_s = LANE1;
                LANE1:   state_nxt_s = LANE2;
                LANE2:   state_nxt_s = LANE3;
                LANE3:   state_nxt_s = LANE0;
                default: state_nxt_s = LANE0;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Lane sequencer state and registered outputs; overflow is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= LANE0;
            data_out_r  <= 8'h00;
            valid_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            data_out_r  <= data_nxt_s;
            valid_out_r <= valid_nxt_s;
            overflow_r  <= overflow_r | drop_s;
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_r[i] <= PTR_ZERO;
                rd_ptr_r[i] <= PTR_ZERO;
                count_r[i]  <= ZERO_CNT;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_ONE;
                    2'b01:   count_r[i] <= count_r[i] - CNT_ONE;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= din_s[i];
            end
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;
    assign lane_ptr  = state_r;
    assign overflow  = overflow_r;

endmodule
